cordic_result_tx: RTL
=====================

CORDIC_RESULT_TX -- requirements
Module: cordic_result_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of result channels per frame (range 1..8).
REQ-002 SHALL have parameter DATA_W, default 42, magnitude bits per channel (range 7..63).
REQ-003 SHALL derive localparam NBYTES = ceil((DATA_W+1)/8), bytes per channel word (6 at defaults).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to capture and send one frame.
REQ-008 data_in  input  NUM_CH*DATA_W  channel magnitudes; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 sign_in  input  NUM_CH  channel sign bits; bit k belongs to channel k.
REQ-010 swap  input  1  when high at capture, channels 0 and 1 (data and sign) exchange places; ignored when NUM_CH=1.
REQ-011 ovr_clr  input  1  clears the overrun flag.
REQ-012 byte_data  output  8  byte offered to the UART byte transmitter.
REQ-013 byte_valid  output  1  byte_data is valid; a byte transfers on a cycle with byte_valid and byte_ready both high.
REQ-014 byte_ready  input  1  downstream transmitter can accept a byte.
REQ-015 busy  output  1  high from the cycle after capture until the frame completes.
REQ-016 frame_done  output  1  one-cycle pulse at frame completion.
REQ-017 overrun  output  1  sticky flag: a start was lost.

Function
REQ-018 SHALL implement states IDLE, SEND (plus HDR and CSUM when configured).
REQ-019 In IDLE, start high SHALL capture data_in, sign_in and swap into internal registers that same edge, then enter SEND (or HDR); busy and byte_valid SHALL be high on the next cycle.
REQ-020 Each channel word SHALL be {sign, (NBYTES*8-1-DATA_W) zero bits, magnitude}, NBYTES*8 bits wide.
REQ-021 Bytes SHALL be sent channel 0 first, then ascending channel index, most-significant byte first within each word.
REQ-022 byte_data SHALL hold stable while byte_valid is high and byte_ready is low; byte_valid SHALL not drop before the transfer.
REQ-023 On a transfer, the next byte SHALL be presented on the following cycle with no idle gap.
REQ-024 Captured registers SHALL not change while busy; input changes during a frame SHALL not affect the bytes sent.
REQ-025 On transfer of the final byte, the block SHALL return to IDLE; frame_done SHALL pulse for exactly one cycle on the next cycle, with busy and byte_valid low in that cycle.
REQ-026 start high while not in IDLE, including the cycle the final byte transfers, SHALL be ignored and SHALL set overrun on the next edge.
REQ-027 ovr_clr SHALL clear overrun; when ovr_clr and a new overrun occur in the same cycle, overrun SHALL be set.
REQ-028 A byte counter SHALL count 0..NUM_CH*NBYTES-1 and SHALL reset to 0 at each capture.

Reset
REQ-029 rst SHALL return the block to IDLE in the following cycle from any state, aborting any frame in progress without asserting frame_done.
REQ-030 After reset: byte_data=0, byte_valid=0, busy=0, frame_done=0, overrun=0, captured registers=0, counter=0.
REQ-031 start sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-032 Macro CORDIC_RESULT_TX_FRAMING_EN: when defined, a header byte 0xA5 SHALL precede the channel bytes (state HDR), and a checksum byte SHALL follow them (state CSUM). The checksum is the XOR of all channel bytes and excludes the header; the frame is NUM_CH*NBYTES+2 bytes.
REQ-033 When CORDIC_RESULT_TX_FRAMING_EN is undefined, the HDR and CSUM states and the checksum logic SHALL not exist, and the frame is NUM_CH*NBYTES bytes.

Verification
REQ-034 Defaults, macro off, byte_ready held high: start with ch0=42'h155_5555_5555, sign0=1, ch1=42'h0AA_AAAA_AAAA, sign1=0, swap=0 -> 12 consecutive bytes 81 55 55 55 55 55 00 AA AA AA AA AA, then frame_done pulses once.
REQ-035 Same data with swap=1 -> 00 AA AA AA AA AA 81 55 55 55 55 55.
REQ-036 byte_ready toggled 1-0-0-1 pseudo-randomly -> byte_data and byte_valid stay stable during stalls; the byte sequence is unchanged.
REQ-037 start pulsed at byte 3 and again on the final-byte transfer cycle -> both ignored, overrun=1 after the first; ovr_clr -> overrun=0.
REQ-038 rst asserted at byte 5 -> next cycle all outputs are 0 and no frame_done; a new start sends a full frame.
REQ-039 Macro on, NUM_CH=1, DATA_W=15, data=15'h1234, sign=1 -> A5 92 34 A6.

Source files
------------

// File: rtl/cordic_result_tx.sv
// Serialises captured CORDIC channel results (sign + magnitude) into a byte stream, MS byte first.
// Optional framing (header 0xA5 + XOR checksum) is enabled by defining CORDIC_RESULT_TX_FRAMING_EN.
module cordic_result_tx #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 42
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    input  logic [NUM_CH-1:0]          sign_in,
    input  logic                       swap,
    input  logic                       ovr_clr,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int NBYTES   = (DATA_W + 8) / 8;
    localparam int WORD_W   = NBYTES * 8;
    localparam int NB_TOTAL = NUM_CH * NBYTES;
    localparam int FRAME_W  = NB_TOTAL * 8;
    localparam int CNT_W    = (NB_TOTAL > 1) ? $clog2(NB_TOTAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_TOTAL - 1);

`ifdef CORDIC_RESULT_TX_FRAMING_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]          sign_q, sign_d;
    logic                       done_q, done_d;
    logic                       ovr_q, ovr_d;

    logic [NUM_CH*DATA_W-1:0]   data_sw;
    logic [NUM_CH-1:0]          sign_sw;
    logic [FRAME_W-1:0]         frame_w;
    logic [FRAME_W-1:0]         frame_sh;
    logic [7:0]                 cur_byte;
    logic [7:0]                 byte_d;

    // Swap is resolved at capture so the serialiser only ever sees final channel order.
    if (NUM_CH > 1) begin : g_swap
        always_comb begin
            data_sw = data_in;
            sign_sw = sign_in;
            if (swap) begin
                data_sw[0 +: DATA_W]      = data_in[DATA_W +: DATA_W];
                data_sw[DATA_W +: DATA_W] = data_in[0 +: DATA_W];
                sign_sw[0]                = sign_in[1];
                sign_sw[1]                = sign_in[0];
            end
        end
    end else begin : g_noswap
        logic unused_swap;
        assign unused_swap = swap;
        assign data_sw     = data_in;
        assign sign_sw     = sign_in;
    end

    always_comb begin
        frame_w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            frame_w[(NUM_CH-1-k)*WORD_W +: DATA_W]    = data_q[k*DATA_W +: DATA_W];
            frame_w[(NUM_CH-1-k)*WORD_W + WORD_W - 1] = sign_q[k];
        end
    end

    assign frame_sh = frame_w << {cnt_q, 3'b000};
    assign cur_byte = frame_sh[FRAME_W-1 -: 8];

`ifdef CORDIC_RESULT_TX_FRAMING_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < NB_TOTAL; i++) begin
            csum = csum ^ frame_w[i*8 +: 8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            sign_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q & ~ovr_clr;
        byte_d  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d = data_sw;
                    sign_d = sign_sw;
                    cnt_d  = '0;
`ifdef CORDIC_RESULT_TX_FRAMING_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end
            end
`ifdef CORDIC_RESULT_TX_FRAMING_EN
            HDR: begin
                byte_d = 8'hA5;
                if (byte_ready) state_d = SEND;
            end
            CSUM: begin
                byte_d = csum;
                if (byte_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            SEND: begin
                byte_d = cur_byte;
                if (byte_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef CORDIC_RESULT_TX_FRAMING_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A start outside IDLE is dropped; it wins over a simultaneous clear.
        if (start && (state_q != IDLE)) ovr_d = 1'b1;
    end

    assign byte_data  = byte_d;
    assign byte_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule
